// File: rtl/uart_rx_oversample.sv
// UART receiver with 16x oversampling and a per-frame latched baud divisor.
// Decodes 8N1 frames, flags a 0 stop bit as a framing error and waits out line breaks.
module uart_rx_oversample #(
    parameter logic [11:0] DIV0 = 12'd325,
    parameter logic [11:0] DIV1 = 12'd162,
    parameter logic [11:0] DIV2 = 12'd80,
    parameter logic [11:0] DIV3 = 12'd40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_rx_meta;
    logic        r_rx_sync;
    logic [11:0] r_div;
    logic [11:0] r_cnt;
    logic [3:0]  r_samp;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_err;

    logic        w_rx;
    logic        w_tick;
    logic [11:0] w_div_sel;

    assign w_rx   = r_rx_sync;
    assign w_tick = (r_state != S_IDLE) && (r_cnt == r_div);

    always_comb begin
        w_div_sel = DIV0;
        case (sel)
            2'b00:   w_div_sel = DIV0;
            2'b01:   w_div_sel = DIV1;
            2'b10:   w_div_sel = DIV2;
            default: w_div_sel = DIV3;
        endcase
    end

    // Synchronizer flops reset to the idle-high line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_div   <= DIV0;
            r_cnt   <= 12'd0;
            r_samp  <= 4'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (r_state == S_IDLE || w_tick) r_cnt <= 12'd0;
            else                             r_cnt <= r_cnt + 12'd1;

            case (r_state)
                S_IDLE: begin
                    r_samp <= 4'd0;
                    r_bit  <= 3'd0;
                    if (!w_rx) begin
                        r_div   <= w_div_sel;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_samp == 4'd7) begin
                            r_samp <= 4'd0;
                            r_state <= w_rx ? S_IDLE : S_DATA;
                        end else begin
                            r_samp <= r_samp + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    // The sample counter wraps every 16 ticks, so bit centres fall on samp==15.
                    if (w_tick) begin
                        r_samp <= r_samp + 4'd1;
                        if (r_samp == 4'd15) begin
                            r_shift <= {w_rx, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                            if (r_bit == 3'd7) r_state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_samp <= r_samp + 4'd1;
                        if (r_samp == 4'd15) begin
                            if (w_rx) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= S_BREAK;
                            end
                        end
                    end
                end
                S_BREAK: begin
                    if (w_rx) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_err;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: frames are scheduled into an event model
// computed from bit timing, and every cycle the outputs are compared against it.
module tb_uart_rx_oversample;

    localparam int D0 = 20;
    localparam int D1 = 9;
    localparam int D2 = 80;
    localparam int D3 = 40;

    typedef struct {
        int         cyc;
        bit         err;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] sel = 2'b11;
    logic       rx = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int   cyc = 0;
    bit   rst_seen = 1'b0;
    bit   chk_en = 1'b0;
    int   n_vec = 0;
    int   n_fail = 0;
    int   n_valid = 0;
    int   last_valid_cyc = -1;
    logic [7:0] model_dout = 8'h00;
    ev_t  exp_q[$];

    uart_rx_oversample #(
        .DIV0(12'd20),
        .DIV1(12'd9),
        .DIV2(12'd80),
        .DIV3(12'd40)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Compare process: a frame's outcome lands 3 + 152*(div+1) cycles after its falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_v;
            logic exp_e;
            ev_t  ev;
            exp_v = 1'b0;
            exp_e = 1'b0;
            if (rst_seen) model_dout = 8'h00;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                ev = exp_q.pop_front();
                if (ev.err) begin
                    exp_e = 1'b1;
                end else begin
                    exp_v      = 1'b1;
                    model_dout = ev.data;
                end
            end
            check("data_valid", {31'd0, data_valid}, {31'd0, exp_v});
            check("frame_err", {31'd0, frame_err}, {31'd0, exp_e});
            check("data_out", {24'd0, data_out}, {24'd0, model_dout});
            if (data_valid === 1'b1) begin
                n_valid++;
                last_valid_cyc = cyc;
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int div, input bit stop_val, input int extra_bits);
        int  p;
        ev_t ev;
        p       = 16 * (div + 1);
        ev.cyc  = cyc + 3 + 152 * (div + 1);
        ev.err  = !stop_val;
        ev.data = d;
        exp_q.push_back(ev);
        rx = 1'b0;
        wait_cyc(p);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_cyc(p);
        end
        rx = stop_val;
        wait_cyc(p * (1 + extra_bits));
    endtask

    initial begin
        int k_first;
        int p3;
        p3 = 16 * (D3 + 1);

        // Reset held 3 cycles with the line low.
        repeat (3) @(posedge clk);
        #1;
        check("reset data_out", {24'd0, data_out}, 32'h00);
        check("reset data_valid", {31'd0, data_valid}, 32'd0);
        check("reset frame_err", {31'd0, frame_err}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        chk_en = 1'b1;
        reset  = 1'b0;
        rx     = 1'b1;
        wait_cyc(40);

        // Normal frame at 41x16 clocks per bit.
        sel = 2'b11;
        k_first = cyc;
        send_frame(8'hA5, D3, 1'b1, 0);
        wait_cyc(40);
        check("a5 data_out", {24'd0, data_out}, 32'hA5);
        check("a5 pulse count", n_valid, 32'd1);
        check("a5 latency", last_valid_cyc - k_first, 32'd6235);

        // False start: low for 5 ticks, then back high.
        sel = 2'b10;
        rx  = 1'b0;
        wait_cyc(5 * (D2 + 1));
        check("false start busy high", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        wait_cyc(3 * (D2 + 1) + 10);
        check("false start busy low", {31'd0, busy}, 32'd0);
        wait_cyc(40);

        // Framing error with the line held low 2 extra bit periods.
        sel = 2'b01;
        send_frame(8'h3C, D1, 1'b0, 2);
        check("break busy high", {31'd0, busy}, 32'd1);
        check("break data_out kept", {24'd0, data_out}, 32'hA5);
        rx = 1'b1;
        wait_cyc(4);
        check("break busy low", {31'd0, busy}, 32'd0);
        wait_cyc(40);

        // Back-to-back frames with no idle gap.
        sel = 2'b00;
        send_frame(8'h01, D0, 1'b1, 0);
        send_frame(8'hFF, D0, 1'b1, 0);
        wait_cyc(40);
        check("b2b data_out", {24'd0, data_out}, 32'hFF);
        check("b2b pulse count", n_valid, 32'd3);

        // Sel changes mid-frame; the divisor latched at the start edge must hold.
        sel = 2'b11;
        fork
            send_frame(8'h96, D3, 1'b1, 0);
            begin
                wait_cyc(3 * p3);
                sel = 2'b00;
            end
        join
        wait_cyc(40);
        check("sel change data_out", {24'd0, data_out}, 32'h96);

        // Reset during data bit 4 aborts with no pulse.
        sel = 2'b11;
        rx  = 1'b0;
        wait_cyc(p3);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(8'h5A >> i);
            wait_cyc(p3);
        end
        rx = 1'b1;
        wait_cyc(p3 / 2);
        check("abort busy before reset", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort data_out", {24'd0, data_out}, 32'h00);
        wait_cyc(2 * p3);
        check("abort pulse count", n_valid, 32'd4);
        check("pending events", exp_q.size(), 32'd0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
